// File: rtl/bcd_down_counter_pkg.sv
// Shared BCD constants and helpers for the down-counter slice.
// Imported by the digit cell and the top.
package bcd_pkg;

   localparam int         BCD_W    = 4;
   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   function automatic logic [BCD_W-1:0] bcd_clamp(
      input logic [BCD_W-1:0] d
   );
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_down_counter_digit.sv
// One BCD digit of the down-counter.
// Steps d -> d-1 on dec_in, with 0 wrapping to 9 only when wrap_en is set.
module bcd_digit_down
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [BCD_W-1:0] ld_d,
   input  logic             dec_in,
   input  logic             wrap_en,
   output logic [BCD_W-1:0] d,
   output logic             is_zero,
   output logic             borrow_out
);

   logic [BCD_W-1:0] r_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d <= BCD_ZERO;
      end else if (load) begin
         r_d <= bcd_clamp(ld_d);
      end else if (dec_in) begin
         if (r_d == BCD_ZERO) begin
            // In saturate mode at all-zero every digit holds.
            if (wrap_en) r_d <= BCD_MAX;
         end else begin
            r_d <= r_d - 4'd1;
         end
      end
   end

   assign d          = r_d;
   assign is_zero    = (r_d == BCD_ZERO);
   assign borrow_out = dec_in & is_zero;

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter with parallel load, enable and borrow-out.
// Digits ripple their borrow upward; z is the borrow out of the top digit.
module bcd_down_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int WRAP   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  x,
   output logic [4*DIGITS-1:0]   q,
   output logic                  zero,
   output logic                  z
);

   logic [DIGITS:0]   w_borrow;
   logic [DIGITS-1:0] w_is_zero;
   logic              w_wrap_en;

   assign w_borrow[0] = x & ~load;
   assign zero        = &w_is_zero;
   assign w_wrap_en   = (WRAP != 0) | ~zero;
   assign z           = w_borrow[DIGITS];

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_down u_digit (
         .clk        (clk),
         .rst_n      (rst_n),
         .load       (load),
         .ld_d       (load_val[4*i +: 4]),
         .dec_in     (w_borrow[i]),
         .wrap_en    (w_wrap_en),
         .d          (q[4*i +: 4]),
         .is_zero    (w_is_zero[i]),
         .borrow_out (w_borrow[i+1])
      );
   end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: a wrapping and a saturating
// instance share one stimulus stream.
module tb_bcd_down_counter;

   logic       clk;
   logic       rst_n;
   logic       load;
   logic [7:0] load_val;
   logic       x;
   logic [7:0] q_w;
   logic       zero_w;
   logic       z_w;
   logic [7:0] q_s;
   logic       zero_s;
   logic       z_s;

   int checks;
   int failures;

   bcd_down_counter #(.DIGITS(2), .WRAP(1)) u_wrap (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .x        (x),
      .q        (q_w),
      .zero     (zero_w),
      .z        (z_w)
   );

   bcd_down_counter #(.DIGITS(2), .WRAP(0)) u_sat (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .x        (x),
      .q        (q_s),
      .zero     (zero_s),
      .z        (z_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic drive(
      input logic       ld,
      input logic [7:0] lv,
      input logic       xx
   );
      @(negedge clk);
      load     = ld;
      load_val = lv;
      x        = xx;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   int val;

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      load     = 1'b0;
      load_val = 8'h00;
      x        = 1'b0;

      #2;
      check("rst_q", 32'(q_w), 32'h00);
      check("rst_zero", 32'(zero_w), 32'h1);
      check("rst_z", 32'(z_w), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: asynchronous reset mid-count
      drive(1'b1, 8'h57, 1'b0);
      tick();
      check("t1_load", 32'(q_w), 32'h57);
      check("t1_nzero", 32'(zero_w), 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_async_q", 32'(q_w), 32'h00);
      check("t1_async_zero", 32'(zero_w), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // 2: load 0x12, count down 13 times through wrap
      drive(1'b1, 8'h12, 1'b0);
      tick();
      check("t2_load", 32'(q_w), 32'h12);
      val = 12;
      for (int i = 0; i < 13; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         check($sformatf("t2_z%0d", i), 32'(z_w), 32'(val == 0));
         tick();
         val = (val == 0) ? 99 : val - 1;
         check($sformatf("t2_q%0d", i), 32'(q_w), 32'(to_bcd(val)));
      end

      // 3: saturating instance holds at zero
      drive(1'b1, 8'h01, 1'b0);
      tick();
      check("t3_load", 32'(q_s), 32'h01);
      for (int i = 1; i <= 3; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         check($sformatf("t3_z%0d", i), 32'(z_s), 32'(i >= 2));
         tick();
         check($sformatf("t3_q%0d", i), 32'(q_s), 32'h00);
         check($sformatf("t3_zero%0d", i), 32'(zero_s), 32'h1);
      end
      check("t3_wrap_q", 32'(q_w), 32'h98);

      // 4: load beats x at zero, z suppressed
      drive(1'b1, 8'h35, 1'b1);
      check("t4_z", 32'(z_s), 32'h0);
      check("t4_zero", 32'(zero_s), 32'h1);
      tick();
      check("t4_q", 32'(q_s), 32'h35);

      // 5: illegal BCD clamped on load
      drive(1'b1, 8'hAF, 1'b0);
      tick();
      check("t5_clamp", 32'(q_w), 32'h99);
      drive(1'b0, 8'h00, 1'b1);
      tick();
      check("t5_dec", 32'(q_w), 32'h98);

      // 6: hold with x=0, then a borrow across digits
      drive(1'b1, 8'h40, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 8'h00, 1'b0);
         check($sformatf("t6_hz%0d", i), 32'(z_w), 32'h0);
         tick();
         check($sformatf("t6_hq%0d", i), 32'(q_w), 32'h40);
      end
      drive(1'b0, 8'h00, 1'b1);
      tick();
      check("t6_dec", 32'(q_w), 32'h39);

      // multi-digit borrow on an otherwise mid-range value
      drive(1'b1, 8'h70, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b1);
      tick();
      check("t7_borrow", 32'(q_s), 32'h69);
      drive(1'b0, 8'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
